// File: rtl/pool_layer_ctrl.sv
// -----------------------------------------------------------------------------
// pool_layer_ctrl
//   Sequencer for the ReLU + 2x2/stride-2 max-pool stage. A pass walks every
//   pooling window of an IN_WIDTH x IN_WIDTH signed image that lives in a
//   sync-read memory. It fetches the in-range pixels of each window one tap at
//   a time and writes max(0, pixels) to the pooled-map buffer. The buffer can
//   apply backpressure through out_ready.
//
// Ports
//   clk, rst_n    clock (rising edge), async active-low reset
//   start         begin a pass; only looked at while idle
//   busy          high while a pass is in progress
//   done          one-cycle pulse when the pass completes
//   mem_rd_en     read strobe to the image memory
//   mem_addr      row*IN_WIDTH+col; 0 when mem_rd_en is low
//   mem_rd_data   signed pixel, valid the cycle after mem_rd_en
//   out_wr_en     pooled result valid
//   out_ready     buffer accepts; transfer on out_wr_en && out_ready
//   out_addr      orow*OUT_WIDTH+ocol; 0 when out_wr_en is low
//   out_data      pooled value (never negative)
// -----------------------------------------------------------------------------
module pool_layer_ctrl #(
  parameter int IN_WIDTH  = 5,
  parameter int OUT_WIDTH = 3,
  parameter int DATA_W    = 32,
  parameter int IN_AW     = $clog2(IN_WIDTH**2),
  parameter int OUT_AW    = $clog2(OUT_WIDTH**2)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd_en,
  output logic [IN_AW-1:0]         mem_addr,
  input  logic signed [DATA_W-1:0] mem_rd_data,
  output logic                     out_wr_en,
  input  logic                     out_ready,
  output logic [OUT_AW-1:0]        out_addr,
  output logic signed [DATA_W-1:0] out_data
);

  localparam int CW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, READ, CAPT, SKIP, WRITE, DONE} state_t;

  // Result of resolving one tap: whether the pixel lies inside the image,
  // and its memory address if it does.
  typedef struct packed {
    logic             hit;
    logic [IN_AW-1:0] addr;
  } tap_t;

  // Taps go (0,0),(0,1),(1,0),(1,1). On odd-sized maps the right and bottom
  // windows hang over the edge, and those taps are skipped.
  function automatic tap_t tap_lookup(input int orow_i, input int ocol_i,
                                      input int tap_i);
    tap_t t;
    int   r;
    int   c;
    r      = 2 * orow_i + tap_i / 2;
    c      = 2 * ocol_i + tap_i % 2;
    t.hit  = (r < IN_WIDTH) && (c < IN_WIDTH);
    t.addr = t.hit ? IN_AW'(r * IN_WIDTH + c) : '0;
    return t;
  endfunction

  state_t                     state;
  logic [CW-1:0]              orow;
  logic [CW-1:0]              ocol;
  logic [1:0]                 tap;
  logic signed [DATA_W-1:0]   acc;

  logic signed [DATA_W-1:0]   acc_new;
  logic                       last_col;
  logic                       last_win;
  logic [CW-1:0]              nxt_orow;
  logic [CW-1:0]              nxt_ocol;
  tap_t                       next_tap;   // next tap in the current window
  tap_t                       first_tap;  // tap 0 of the following window
  tap_t                       start_tap;  // tap 0 of window (0,0)

  // NOTE: every signal driven here gets a value on every path, so the
  // block stays purely combinational and no latch is inferred.
  always_comb begin
    acc_new   = acc;
    if (state == CAPT && mem_rd_data > acc) acc_new = mem_rd_data;
    last_col  = (int'(ocol) == OUT_WIDTH - 1);
    last_win  = last_col && (int'(orow) == OUT_WIDTH - 1);
    nxt_ocol  = last_col ? '0 : ocol + CW'(1);
    nxt_orow  = last_col ? orow + CW'(1) : orow;
    next_tap  = tap_lookup(int'(orow), int'(ocol), int'(tap) + 1);
    first_tap = tap_lookup(int'(nxt_orow), int'(nxt_ocol), 0);
    start_tap = tap_lookup(0, 0, 0);
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // branch reads the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      orow      <= '0;
      ocol      <= '0;
      tap       <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      out_wr_en <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            orow <= '0;
            ocol <= '0;
            tap  <= '0;
            acc  <= '0;
            busy <= 1'b1;
            if (start_tap.hit) begin
              state     <= READ;
              mem_rd_en <= 1'b1;
              mem_addr  <= start_tap.addr;
            end else begin
              state <= SKIP;
            end
          end
        end

        // The strobe lasts exactly one cycle. The pixel arrives during CAPT.
        READ: begin
          state     <= CAPT;
          mem_rd_en <= 1'b0;
          mem_addr  <= '0;
        end

        // A skipped tap and a captured tap differ only in acc_new, so both
        // states share the code that advances the tap.
        CAPT, SKIP: begin
          acc <= acc_new;
          if (tap == 2'd3) begin
            state     <= WRITE;
            out_wr_en <= 1'b1;
            out_addr  <= OUT_AW'(int'(orow) * OUT_WIDTH + int'(ocol));
            out_data  <= acc_new;
          end else begin
            tap <= tap + 2'd1;
            if (next_tap.hit) begin
              state     <= READ;
              mem_rd_en <= 1'b1;
              mem_addr  <= next_tap.addr;
            end else begin
              state <= SKIP;
            end
          end
        end

        // Address and data hold until the buffer accepts the write.
        WRITE: begin
          if (out_ready) begin
            out_wr_en <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            acc       <= '0;
            tap       <= '0;
            if (last_win) begin
              state <= DONE;
              orow  <= '0;
              ocol  <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              orow <= nxt_orow;
              ocol <= nxt_ocol;
              if (first_tap.hit) begin
                state     <= READ;
                mem_rd_en <= 1'b1;
                mem_addr  <= first_tap.addr;
              end else begin
                state <= SKIP;
              end
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
